// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: packet/width encodings and size helpers.
package noc_pkg;

  typedef enum logic [2:0] {
    DMEM_REQ_READ     = 3'd0,
    DMEM_REQ_WRITE    = 3'd1,
    DMEM_RESP_DATA    = 3'd2,
    DMEM_RESP_WRITTEN = 3'd3,
    DMEM_RESP_BAD     = 3'd4,
    IMEM_REQ_READ     = 3'd5,
    IMEM_RESP_DATA    = 3'd6,
    IMEM_RESP_BAD     = 3'd7
  } type_packet_type;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  typedef struct packed {
    int x;
    int y;
  } xy_t;

  // Payload bytes carried by a packet; the unused width code counts as a word.
  function automatic int bytes_for(type_packet_type t, type_scr1_mem_width_e w);
    int wb;
    case (w)
      SCR1_MEM_WIDTH_BYTE:  wb = 1;
      SCR1_MEM_WIDTH_HWORD: wb = 2;
      default:              wb = 4;
    endcase
    case (t)
      DMEM_REQ_READ, IMEM_REQ_READ, IMEM_RESP_DATA: return 4;
      DMEM_RESP_DATA:                               return wb;
      DMEM_REQ_WRITE:                               return 4 + wb;
      default:                                      return 0;
    endcase
  endfunction

  // Flits needed for a payload: at least one, never more than max_flits.
  function automatic int flit_count(int nbytes, int flit_payload, int max_flits);
    int n;
    n = (nbytes * 8 + flit_payload - 1) / flit_payload;
    if (n < 1) n = 1;
    if (n > max_flits) n = max_flits;
    return n;
  endfunction

  // Linear node id to mesh coordinates.
  function automatic xy_t node_to_xy(int id, int cols);
    xy_t p;
    p.x = id % cols;
    p.y = id / cols;
    return p;
  endfunction

endpackage

// File: rtl/noc_pkt_fifo.sv
// Single-clock FIFO holding whole packet entries; head is visible combinationally.
module noc_pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr_reg];

  // Storage write, no reset needed on the data itself.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
      else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/noc_flit_packetizer.sv
// Multi-channel packet queueing, round-robin packet arbitration and flit serialisation.
module noc_flit_packetizer
  import noc_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int NODE_ID         = 0,
  parameter int X               = 3,
  parameter int Y               = 3,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int QUEUE_DEPTH     = 8,
  parameter int MAX_PAYLOAD     = 64,
  parameter int FLIT_PAYLOAD    = 8,
  localparam int COORD_W    = $clog2(X) + $clog2(Y),
  localparam int MAX_FLITS  = MAX_PAYLOAD / FLIT_PAYLOAD,
  localparam int IDX_W      = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1,
  localparam int FLIT_WIDTH = 1 + COORD_W + 3 + 2 + PACKET_ID_WIDTH + COORD_W + IDX_W + FLIT_PAYLOAD
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [CHANNELS-1:0]                       in_valid,
  output logic [CHANNELS-1:0]                       in_ready,
  input  logic [CHANNELS-1:0][MAX_PAYLOAD-1:0]      in_payload,
  input  logic [CHANNELS-1:0][$clog2(X*Y)-1:0]      in_node_dest,
  input  logic [CHANNELS-1:0][2:0]                  in_packet_type,
  input  logic [CHANNELS-1:0][1:0]                  in_mem_width,
  input  logic [CHANNELS-1:0][PACKET_ID_WIDTH-1:0]  in_packet_id,
  output logic [FLIT_WIDTH-1:0]                     out_flit,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [CHANNELS-1:0]                       err_drop
);
  localparam int XW  = $clog2(X);
  localparam int YW  = $clog2(Y);
  localparam int N_W = $clog2(MAX_FLITS + 1);
  localparam int GW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [COORD_W-1:0] SRC_XY = {XW'(NODE_ID % X), YW'(NODE_ID / X)};

  typedef struct packed {
    logic [MAX_PAYLOAD-1:0]     payload;
    logic [COORD_W-1:0]         dest_xy;
    type_packet_type            ptype;
    type_scr1_mem_width_e       width;
    logic [PACKET_ID_WIDTH-1:0] id;
    logic [N_W-1:0]             n;
  } entry_t;

  typedef struct packed {
    logic                       last;
    logic [COORD_W-1:0]         dest_xy;
    type_packet_type            ptype;
    type_scr1_mem_width_e       width;
    logic [PACKET_ID_WIDTH-1:0] id;
    logic [COORD_W-1:0]         src_xy;
    logic [IDX_W-1:0]           idx;
    logic [FLIT_PAYLOAD-1:0]    payload;
  } flit_t;

  function automatic logic [COORD_W-1:0] xy_bits(int id);
    xy_t p;
    p = node_to_xy(id, X);
    return {XW'(p.x), YW'(p.y)};
  endfunction

  // Flit k of an entry; packets without payload send a zero payload field.
  function automatic flit_t build_flit(entry_t e, logic [IDX_W-1:0] k);
    flit_t f;
    f.last    = (int'(k) + 1 == int'(e.n));
    f.dest_xy = e.dest_xy;
    f.ptype   = e.ptype;
    f.width   = e.width;
    f.id      = e.id;
    f.src_xy  = SRC_XY;
    f.idx     = k;
    f.payload = (bytes_for(e.ptype, e.width) == 0) ? '0
              : e.payload[int'(k)*FLIT_PAYLOAD +: FLIT_PAYLOAD];
    return f;
  endfunction

  // First non-empty channel strictly after ptr, wrapping around.
  function automatic logic [GW-1:0] pick_grant(logic [CHANNELS-1:0] emp, logic [GW-1:0] ptr);
    logic [GW-1:0] g;
    int c;
    g = ptr;
    for (int i = CHANNELS; i >= 1; i--) begin
      c = (int'(ptr) + i) % CHANNELS;
      if (!emp[c]) g = GW'(c);
    end
    return g;
  endfunction

  entry_t              in_entry [CHANNELS];
  entry_t              head     [CHANNELS];
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] drop;
  logic [CHANNELS-1:0] pop_ch;
  logic [CHANNELS-1:0] err_drop_reg;

  state_e           state_reg, state_next;
  logic [GW-1:0]    grant_reg, grant_next;
  logic [GW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             out_valid_reg, out_valid_next;
  flit_t            out_flit_reg, out_flit_next;
  logic             pop_req;
  logic [GW-1:0]    grant_pick;
  entry_t           cur_entry;
  entry_t           pick_entry;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic dest_ok;
      assign dest_ok = int'(in_node_dest[gi]) < X * Y;
      assign push[gi] = in_valid[gi] & ~full[gi] & dest_ok;
      assign drop[gi] = in_valid[gi] & ~full[gi] & ~dest_ok;
      assign pop_ch[gi] = pop_req && (grant_reg == GW'(gi));
      assign in_entry[gi] = '{
        payload: in_payload[gi],
        dest_xy: xy_bits(int'(in_node_dest[gi])),
        ptype:   type_packet_type'(in_packet_type[gi]),
        width:   type_scr1_mem_width_e'(in_mem_width[gi]),
        id:      in_packet_id[gi],
        n:       N_W'(flit_count(bytes_for(type_packet_type'(in_packet_type[gi]),
                                           type_scr1_mem_width_e'(in_mem_width[gi])),
                                 FLIT_PAYLOAD, MAX_FLITS))
      };

      noc_pkt_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (QUEUE_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[gi]),
        .pop   (pop_ch[gi]),
        .din   (in_entry[gi]),
        .dout  (head[gi]),
        .full  (full[gi]),
        .empty (empty[gi])
      );
    end
  endgenerate

  assign in_ready   = ~full;
  assign err_drop   = err_drop_reg;
  assign out_valid  = out_valid_reg;
  assign out_flit   = out_flit_reg;
  assign grant_pick = pick_grant(empty, rr_ptr_reg);
  assign cur_entry  = head[grant_reg];
  assign pick_entry = head[grant_pick];

  // Drop-error pulse, one cycle after the rejected packet was accepted.
  always_ff @(posedge clk) begin
    if (rst) err_drop_reg <= '0;
    else     err_drop_reg <= drop;
  end

  // Serialiser state register; reset discards any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= GW'(CHANNELS - 1);
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_flit_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      idx_reg       <= idx_next;
      out_valid_reg <= out_valid_next;
      out_flit_reg  <= out_flit_next;
    end
  end

  // Grant a packet in IDLE, step through its flits in SEND, pop on the last one.
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    idx_next       = idx_reg;
    out_valid_next = out_valid_reg;
    out_flit_next  = out_flit_reg;
    pop_req        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (~&empty) begin
          grant_next     = grant_pick;
          idx_next       = '0;
          out_flit_next  = build_flit(pick_entry, '0);
          out_valid_next = 1'b1;
          state_next     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (int'(idx_reg) + 1 == int'(cur_entry.n)) begin
            pop_req        = 1'b1;
            rr_ptr_next    = grant_reg;
            out_valid_next = 1'b0;
            idx_next       = '0;
            state_next     = ST_IDLE;
          end else begin
            idx_next      = idx_reg + 1'b1;
            out_flit_next = build_flit(cur_entry, idx_reg + 1'b1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Self-checking bench: cycle-level behavioural model with per-channel packet queues.
module tb_noc_flit_packetizer;
  localparam int CH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
  logic [CH-1:0][63:0] in_payload;
  logic [CH-1:0][3:0]  in_node_dest;
  logic [CH-1:0][2:0]  in_packet_type;
  logic [CH-1:0][1:0]  in_mem_width;
  logic [CH-1:0][4:0]  in_packet_id;
  logic [29:0]         out_flit;
  logic                out_valid;
  logic                out_ready;
  logic [CH-1:0]       err_drop;

  noc_flit_packetizer dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_payload     (in_payload),
    .in_node_dest   (in_node_dest),
    .in_packet_type (in_packet_type),
    .in_mem_width   (in_mem_width),
    .in_packet_id   (in_packet_id),
    .out_flit       (out_flit),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .err_drop       (err_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] payload;
    int dest;
    int ptype;
    int width;
    int id;
  } pkt_t;

  pkt_t        mq [CH][$];
  bit          active = 0;
  int          cur_ch = 0;
  int          cur_k = 0;
  int          last_g = CH - 1;
  logic [CH-1:0] err_exp = '0;
  bit          rst_pend = 0;
  logic [29:0] got[$];
  int          err_seen = 0;

  function automatic int pkt_bytes(int t, int w);
    int wb;
    wb = (w == 0) ? 1 : (w == 1) ? 2 : 4;
    case (t)
      0, 5, 6: return 4;
      1:       return 4 + wb;
      2:       return wb;
      default: return 0;
    endcase
  endfunction

  function automatic int pkt_flits(int b);
    int n;
    n = (b * 8 + 7) / 8;
    if (n < 1) n = 1;
    if (n > 8) n = 8;
    return n;
  endfunction

  function automatic logic [29:0] exp_flit(pkt_t p, int k);
    int b;
    int n;
    logic [63:0] sh;
    logic [7:0] pl;
    b  = pkt_bytes(p.ptype, p.width);
    n  = pkt_flits(b);
    sh = p.payload >> (8 * k);
    pl = (b == 0) ? 8'h00 : sh[7:0];
    return {(k == n - 1), 2'(p.dest % 3), 2'(p.dest / 3), 3'(p.ptype), 2'(p.width),
            5'(p.id), 4'b0000, 3'(k), pl};
  endfunction

  function automatic int qsum();
    int s;
    s = 0;
    for (int c = 0; c < CH; c++) s += mq[c].size();
    return s;
  endfunction

  // Model + compare: check what the DUT shows now, then advance to the next edge.
  always @(negedge clk) begin
    bit   found;
    pkt_t p;
    if (rst_pend) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_flit", out_flit, 0);
      chk("rst_err_drop", err_drop, 0);
      chk("rst_in_ready", in_ready, 2'b11);
    end
    chk("out_valid", out_valid, active);
    if (active && out_valid) chk("out_flit", out_flit, exp_flit(mq[cur_ch][0], cur_k));
    chk("err_drop", err_drop, err_exp);
    if (err_drop != '0) err_seen++;
    for (int c = 0; c < CH; c++) chk("in_ready", in_ready[c], mq[c].size() < 8);
    if (out_valid && out_ready) got.push_back(out_flit);

    if (rst) begin
      for (int c = 0; c < CH; c++) mq[c].delete();
      active  = 0;
      last_g  = CH - 1;
      err_exp = '0;
    end else begin
      if (active) begin
        if (out_ready) begin
          if (cur_k == pkt_flits(pkt_bytes(mq[cur_ch][0].ptype, mq[cur_ch][0].width)) - 1) begin
            void'(mq[cur_ch].pop_front());
            last_g = cur_ch;
            active = 0;
          end else begin
            cur_k++;
          end
        end
      end else begin
        found = 0;
        for (int i = 1; i <= CH; i++) begin
          if (!found && mq[(last_g + i) % CH].size() > 0) begin
            found  = 1;
            cur_ch = (last_g + i) % CH;
            cur_k  = 0;
            active = 1;
          end
        end
      end
      err_exp = '0;
      for (int c = 0; c < CH; c++) begin
        if (in_valid[c] && in_ready[c]) begin
          if (int'(in_node_dest[c]) < 9) begin
            p.payload = in_payload[c];
            p.dest    = int'(in_node_dest[c]);
            p.ptype   = int'(in_packet_type[c]);
            p.width   = int'(in_mem_width[c]);
            p.id      = int'(in_packet_id[c]);
            mq[c].push_back(p);
          end else begin
            err_exp[c] = 1'b1;
          end
        end
      end
    end
    rst_pend = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(int c, int t, int w, int d, int id, logic [63:0] pl);
    in_valid[c]       = 1'b1;
    in_packet_type[c] = 3'(t);
    in_mem_width[c]   = 2'(w);
    in_node_dest[c]   = 4'(d);
    in_packet_id[c]   = 5'(id);
    in_payload[c]     = pl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(string name, int bound);
    int k;
    k = 0;
    in_valid = '0;
    out_ready = 1'b1;
    while ((active || qsum() > 0) && k < bound) begin
      tick();
      k++;
    end
    chk(name, (k >= bound), 0);
    tick();
    tick();
  endtask

  task automatic wait_idx(string name, int want);
    int k;
    k = 0;
    while (!(out_valid && int'(out_flit[10:8]) == want) && k < 100) begin
      tick();
      k++;
    end
    chk(name, (k >= 100), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t        p1;
    logic [29:0] f;
    logic [29:0] saved;
    int          acc;
    int          k;
    int          cnt2;

    in_valid = '0;
    in_payload = '0;
    in_node_dest = '0;
    in_packet_type = '0;
    in_mem_width = '0;
    in_packet_id = '0;
    out_ready = 1'b1;
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;

    // Pin the model itself against hand-computed flits.
    p1 = '{payload: 64'h1122334455667788, dest: 5, ptype: 1, width: 2, id: 3};
    chk("model_pin_first", exp_flit(p1, 0), 30'h12618088);
    chk("model_pin_last", exp_flit(p1, 7), 30'h32618711);

    // DMEM_REQ_WRITE word on ch0: 8 flits.
    got.delete();
    set_pkt(0, 1, 2, 5, 3, 64'h1122334455667788);
    tick();
    in_valid = '0;
    wait_drain("t1_timeout", 100);
    chk("t1_nflits", got.size(), 8);
    for (int i = 0; i < got.size(); i++) begin
      f = got[i];
      chk("t1_idx", f[10:8], i);
    end
    f = (got.size() > 0) ? got[0] : '0;
    chk("t1_first_flit", f, 30'h12618088);
    f = (got.size() > 7) ? got[7] : '0;
    chk("t1_last_flit", f, 30'h32618711);

    // DMEM_RESP_WRITTEN on ch1: single flit, payload forced to zero.
    got.delete();
    set_pkt(1, 3, 0, 4, 0, 64'hDEADBEEFCAFEF00D);
    tick();
    in_valid = '0;
    wait_drain("t2_timeout", 100);
    chk("t2_nflits", got.size(), 1);
    f = (got.size() > 0) ? got[0] : '0;
    chk("t2_flit", f, 30'h2AC00000);

    // Both channels push two reads each in the same cycles.
    do_reset();
    got.delete();
    set_pkt(0, 0, 2, 1, 1, {$urandom, $urandom});
    set_pkt(1, 0, 2, 2, 2, {$urandom, $urandom});
    tick();
    set_pkt(0, 0, 2, 1, 3, {$urandom, $urandom});
    set_pkt(1, 0, 2, 2, 4, {$urandom, $urandom});
    tick();
    in_valid = '0;
    wait_drain("t3_timeout", 200);
    chk("t3_nflits", got.size(), 16);
    for (int i = 0; i < got.size(); i++) begin
      f = got[i];
      chk("t3_order_id", f[19:15], i / 4 + 1);
    end

    // Backpressure while idx 2 is presented.
    got.delete();
    set_pkt(0, 1, 2, 7, 6, {$urandom, $urandom});
    tick();
    in_valid = '0;
    wait_idx("t4_reach_idx2", 2);
    out_ready = 1'b0;
    saved = out_flit;
    tick(); tick(); tick();
    chk("t4_hold", out_flit, saved);
    out_ready = 1'b1;
    wait_drain("t4_timeout", 100);
    cnt2 = 0;
    for (int i = 0; i < got.size(); i++) begin
      f = got[i];
      if (f[10:8] == 3'd2) cnt2++;
    end
    chk("t4_idx2_once", cnt2, 1);
    f = (got.size() > 3) ? got[3] : '0;
    chk("t4_after_idx2", f[10:8], 3);

    // Fill ch0 with the link stalled.
    do_reset();
    got.delete();
    out_ready = 1'b0;
    set_pkt(0, 3, 0, 2, 9, 64'h0);
    acc = 0;
    k = 0;
    while (acc < 8 && k < 40) begin
      if (in_ready[0]) acc++;
      tick();
      k++;
    end
    chk("t5_accepts", acc, 8);
    chk("t5_full", in_ready[0], 0);
    tick(); tick();
    chk("t5_still_full", in_ready[0], 0);
    out_ready = 1'b1;
    k = 0;
    while (!in_ready[0] && k < 20) begin
      tick();
      k++;
    end
    chk("t5_ready_back", in_ready[0], 1);
    tick();
    in_valid = '0;
    wait_drain("t5_timeout", 200);
    chk("t5_nflits", got.size(), 9);

    // Illegal destination: dropped with a one-cycle error pulse.
    got.delete();
    err_seen = 0;
    set_pkt(0, 0, 2, 9, 1, 64'h55);
    tick();
    in_valid = '0;
    tick(); tick(); tick(); tick();
    chk("t6_err_pulses", err_seen, 1);
    chk("t6_no_flit", got.size(), 0);

    // Reset in the middle of an 8-flit packet.
    set_pkt(0, 1, 2, 5, 3, {$urandom, $urandom});
    tick();
    in_valid = '0;
    wait_idx("t7_reach_idx3", 3);
    rst = 1'b1;
    tick();
    chk("t7_valid_low", out_valid, 0);
    chk("t7_ready_all", in_ready, 2'b11);
    rst = 1'b0;
    got.delete();
    for (int i = 0; i < 6; i++) tick();
    chk("t7_no_residual", out_valid, 0);
    chk("t7_no_flits", got.size(), 0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        set_pkt(c, int'($urandom_range(7)), int'($urandom_range(3)),
                int'($urandom_range(10)), int'($urandom_range(31)), {$urandom, $urandom});
        in_valid[c] = ($urandom_range(2) == 0);
      end
      out_ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0;
    wait_drain("rand_timeout", 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
